// File: rtl/pc_next_unit.sv
// pc_next_unit: architectural PC register, branch/jump target formation and
// branch resolution for the multicycle CPU.
// Optional build macro PC_ALIGN_CHECK_EN: forces pc[1:0] to zero on every
// write and raises a sticky misaligned flag when a write carried nonzero bits.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_WE,
    input  logic [1:0]       PCSrc,
    input  logic [3:0]       Branch,
    input  logic             JAL,
    input  logic             IR_WE,
    input  logic [31:0]      instruction,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic [31:0]      pc,
    output logic [31:0]      branch_target,
    output logic [31:0]      link_addr,
    output logic             branch_taken,
    output logic [CNT_W-1:0] taken_count,
    output logic             misaligned
);

    logic        ir_loaded;
    logic        taken;
    logic        applied;
    logic        pc_write;
    logic [31:0] jump_target;
    logic [31:0] branch_offset;
    logic [31:0] pc_raw;
    logic [31:0] pc_next;

    // Opcode bits are decoded by the control FSM, not here.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, instruction[31:26]};

    assign jump_target   = {pc[31:28], instruction[25:0], 2'b00};
    assign branch_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};

    // Branch resolution and next-PC selection; an FSM write overrides a taken branch.
    always_comb begin
        taken    = ((Branch == 4'd1) && alu_zero) || ((Branch == 4'd2) && !alu_zero);
        applied  = taken && !PC_WE;
        pc_write = 1'b0;
        pc_raw   = pc;
        if (PC_WE) begin
            case (PCSrc)
                2'd0:    begin pc_raw = branch_target; pc_write = 1'b1; end
                2'd1:    begin pc_raw = alu_result;    pc_write = 1'b1; end
                2'd2:    begin pc_raw = jump_target;   pc_write = 1'b1; end
                default: begin pc_raw = pc;            pc_write = 1'b0; end
            endcase
        end else if (taken) begin
            pc_raw   = branch_target;
            pc_write = 1'b1;
        end
`ifdef PC_ALIGN_CHECK_EN
        pc_next = {pc_raw[31:2], 2'b00};
`else
        pc_next = pc_raw;
`endif
    end

    // PC, targets, link address and taken-branch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            branch_target <= '0;
            link_addr     <= '0;
            branch_taken  <= 1'b0;
            taken_count   <= '0;
            ir_loaded     <= 1'b0;
        end else begin
            pc           <= pc_next;
            ir_loaded    <= IR_WE;
            branch_taken <= applied;
            if (ir_loaded)
                branch_target <= pc + branch_offset;
            if (JAL)
                link_addr <= pc;
            if (applied && (taken_count != '1))
                taken_count <= taken_count + CNT_W'(1);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky flag: any PC write whose unforced value had low bits set.
    always_ff @(posedge clk) begin
        if (reset)
            misaligned <= 1'b0;
        else if (pc_write && (pc_raw[1:0] != 2'b00))
            misaligned <= 1'b1;
    end
`else
    logic unused_write;
    assign unused_write = pc_write;
    assign misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit (RESET_PC=0x100, CNT_W=3 so
// saturation is reachable quickly). Honours PC_ALIGN_CHECK_EN when defined.
module tb_pc_next_unit;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          PC_WE;
    logic [1:0]    PCSrc;
    logic [3:0]    Branch;
    logic          JAL;
    logic          IR_WE;
    logic [31:0]   instruction;
    logic [31:0]   alu_result;
    logic          alu_zero;
    logic [31:0]   pc;
    logic [31:0]   branch_target;
    logic [31:0]   link_addr;
    logic          branch_taken;
    logic [CW-1:0] taken_count;
    logic          misaligned;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    pc_next_unit #(
        .RESET_PC (32'h0000_0100),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PC_WE         (PC_WE),
        .PCSrc         (PCSrc),
        .Branch        (Branch),
        .JAL           (JAL),
        .IR_WE         (IR_WE),
        .instruction   (instruction),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .pc            (pc),
        .branch_target (branch_target),
        .link_addr     (link_addr),
        .branch_taken  (branch_taken),
        .taken_count   (taken_count),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        PC_WE = 1'b0; PCSrc = 2'd3; Branch = 4'd0; JAL = 1'b0; IR_WE = 1'b0;
    endtask

    initial begin
        reset = 1'b1; idle(); instruction = '0; alu_result = '0; alu_zero = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_pc", pc, 32'h100);
        check("rst_bt", branch_target, 32'h0);
        check("rst_link", link_addr, 32'h0);
        check("rst_pulse", {31'd0, branch_taken}, 32'd0);
        check("rst_count", {29'd0, taken_count}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);

        // Fetch: PC <- PC+4, load BEQ imm=3
        PC_WE = 1'b1; PCSrc = 2'd1; alu_result = 32'h104; IR_WE = 1'b1;
        instruction = 32'h1022_0003;
        step();
        check("fetch_pc", pc, 32'h104);
        idle();
        step();
        check("beq_bt", branch_target, 32'h110);
        check("beq_pc_hold", pc, 32'h104);
        Branch = 4'd1; alu_zero = 1'b1;
        step(); exp_count++;
        check("beq_pc", pc, 32'h110);
        check("beq_pulse", {31'd0, branch_taken}, 32'd1);
        check("beq_count", {29'd0, taken_count}, exp_count);
        idle();
        step();
        check("beq_pulse_end", {31'd0, branch_taken}, 32'd0);

        // Not-taken cases
        Branch = 4'd2; alu_zero = 1'b1;
        step();
        check("bne_nt_pc", pc, 32'h110);
        check("bne_nt_pulse", {31'd0, branch_taken}, 32'd0);
        check("bne_nt_count", {29'd0, taken_count}, exp_count);
        Branch = 4'd1; alu_zero = 1'b0;
        step();
        check("beq_nt_pc", pc, 32'h110);
        Branch = 4'd5; alu_zero = 1'b1;
        step();
        check("nobr_pc", pc, 32'h110);
        check("nobr_pulse", {31'd0, branch_taken}, 32'd0);

        // BNE taken back to the latched target
        Branch = 4'd2; alu_zero = 1'b0;
        step(); exp_count++;
        check("bne_t_pc", pc, 32'h110);
        check("bne_t_pulse", {31'd0, branch_taken}, 32'd1);
        check("bne_t_count", {29'd0, taken_count}, exp_count);
        idle();

        // J with JAL
        PC_WE = 1'b1; PCSrc = 2'd1; alu_result = 32'h1000_0008;
        step();
        instruction = 32'h0C00_0040; PCSrc = 2'd2; JAL = 1'b1;
        step();
        check("j_pc", pc, 32'h1000_0100);
        check("jal_link", link_addr, 32'h1000_0008);
        JAL = 1'b0; PCSrc = 2'd3;
        step();
        check("hold_pc", pc, 32'h1000_0100);
        check("hold_link", link_addr, 32'h1000_0008);

        // Target wraparound
        PCSrc = 2'd1; alu_result = 32'h4;
        step();
        idle(); IR_WE = 1'b1; instruction = 32'h1022_FFFE;
        step();
        IR_WE = 1'b0;
        step();
        check("wrap_bt", branch_target, 32'hFFFF_FFFC);
        PC_WE = 1'b1; PCSrc = 2'd0;
        step();
        check("src0_pc", pc, 32'hFFFF_FFFC);

        // Conflict: PC_WE overrides a taken branch
        PCSrc = 2'd1; alu_result = 32'h200; Branch = 4'd1; alu_zero = 1'b1;
        step();
        check("conf_pc", pc, 32'h200);
        check("conf_pulse", {31'd0, branch_taken}, 32'd0);
        check("conf_count", {29'd0, taken_count}, exp_count);

        // Saturation: keep taking branches past all-ones
        PC_WE = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (exp_count < 7) exp_count++;
            check("sat_count", {29'd0, taken_count}, exp_count);
            check("sat_pulse", {31'd0, branch_taken}, 32'd1);
        end
        check("sat_final", {29'd0, taken_count}, 32'd7);
        check("sat_pc", pc, 32'hFFFF_FFFC);

        // Reset mid-instruction overrides all controls
        PC_WE = 1'b1; PCSrc = 2'd1; alu_result = 32'h300; JAL = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; idle();
        check("mrst_pc", pc, 32'h100);
        check("mrst_bt", branch_target, 32'h0);
        check("mrst_link", link_addr, 32'h0);
        check("mrst_count", {29'd0, taken_count}, 32'd0);
        check("mrst_pulse", {31'd0, branch_taken}, 32'd0);

        // Alignment check (JR to a misaligned address)
        PC_WE = 1'b1; PCSrc = 2'd1; alu_result = 32'h203;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("jr_pc", pc, 32'h200);
        check("jr_mis", {31'd0, misaligned}, 32'd1);
`else
        check("jr_pc", pc, 32'h203);
        check("jr_mis", {31'd0, misaligned}, 32'd0);
`endif
        alu_result = 32'h208;
        step();
        check("mis_next_pc", pc, 32'h208);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_sticky", {31'd0, misaligned}, 32'd1);
`else
        check("mis_tied", {31'd0, misaligned}, 32'd0);
`endif
        idle(); reset = 1'b1;
        step();
        reset = 1'b0;
        check("mis_clear", {31'd0, misaligned}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
